// File: rtl/ram_true_dp_rf_wre_param_if.sv
// Port bundle for the true dual-port read-first RAM: both access ports plus the collision monitor.
// The master side drives the addresses, data and enables; the slave side is the RAM.
interface ram_true_dp_rf_wre_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int BYTE_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;

  logic                  weA;
  logic                  weB;
  logic                  reA;
  logic                  reB;
  logic [NB-1:0]         beA;
  logic [NB-1:0]         beB;
  logic [ADDR_WIDTH-1:0] addrA;
  logic [ADDR_WIDTH-1:0] addrB;
  logic [DATA_WIDTH-1:0] dinA;
  logic [DATA_WIDTH-1:0] dinB;
  logic [DATA_WIDTH-1:0] doutA;
  logic [DATA_WIDTH-1:0] doutB;
  logic                  collision;
  logic [CNT_WIDTH-1:0]  collision_cnt;

  modport master (
    output weA, weB, reA, reB, beA, beB, addrA, addrB, dinA, dinB,
    input  doutA, doutB, collision, collision_cnt
  );

  modport slave (
    input  weA, weB, reA, reB, beA, beB, addrA, addrB, dinA, dinB,
    output doutA, doutB, collision, collision_cnt
  );
endinterface

// File: rtl/ram_true_dp_rf_wre_param.sv
// Parametrised true dual-port read-first RAM with byte-lane writes, port-A-wins collisions and a
// saturating collision monitor. Define RAM_TDP_OUT_REG_EN for an extra output stage (2-cycle reads).
module ram_true_dp_rf_wre_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int BYTE_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input logic                        clk,
  input logic                        rst,
  ram_true_dp_rf_wre_param_if.slave  bus
);
  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_a;
  logic                  wr_b;
  logic                  coll_d;
  logic                  collision_q;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [DATA_WIDTH-1:0] dout_a_d;
  logic [DATA_WIDTH-1:0] dout_a_q;
  logic [DATA_WIDTH-1:0] dout_b_d;
  logic [DATA_WIDTH-1:0] dout_b_q;

  // Writes are suppressed for the whole time reset is high.
  always_comb begin
    wr_a   = bus.weA & ~rst;
    wr_b   = bus.weB & ~rst;
    coll_d = bus.weA & bus.weB & (bus.addrA == bus.addrB) & (|(bus.beA & bus.beB));
  end

  // NOTE: the array has no reset so it maps onto block RAM; contents survive rst.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_b && bus.beB[i]) begin
        mem[bus.addrB][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.dinB[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    // Port A is scheduled last, so on an overlapping lane at a shared address its byte wins.
    for (int i = 0; i < NB; i++) begin
      if (wr_a && bus.beA[i]) begin
        mem[bus.addrA][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.dinA[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    dout_a_d = dout_a_q;
    dout_b_d = dout_b_q;
    cnt_d    = cnt_q;
    if (bus.reA) dout_a_d = mem[bus.addrA];
    if (bus.reB) dout_b_d = mem[bus.addrB];
    if (coll_d && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // The array read above sees pre-edge contents too, which is what makes reads read-first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_a_q    <= '0;
      dout_b_q    <= '0;
      collision_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      dout_a_q    <= dout_a_d;
      dout_b_q    <= dout_b_d;
      collision_q <= coll_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef RAM_TDP_OUT_REG_EN
  logic                  re_a_q;
  logic                  re_b_q;
  logic [DATA_WIDTH-1:0] dout2_a_d;
  logic [DATA_WIDTH-1:0] dout2_a_q;
  logic [DATA_WIDTH-1:0] dout2_b_d;
  logic [DATA_WIDTH-1:0] dout2_b_q;

  // Stage 2 only advances behind a real read, so a port's output still holds when idle.
  always_comb begin
    dout2_a_d = re_a_q ? dout_a_q : dout2_a_q;
    dout2_b_d = re_b_q ? dout_b_q : dout2_b_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re_a_q    <= 1'b0;
      re_b_q    <= 1'b0;
      dout2_a_q <= '0;
      dout2_b_q <= '0;
    end else begin
      re_a_q    <= bus.reA;
      re_b_q    <= bus.reB;
      dout2_a_q <= dout2_a_d;
      dout2_b_q <= dout2_b_d;
    end
  end

  assign bus.doutA = dout2_a_q;
  assign bus.doutB = dout2_b_q;
`else
  assign bus.doutA = dout_a_q;
  assign bus.doutB = dout_b_q;
`endif

  assign bus.collision     = collision_q;
  assign bus.collision_cnt = cnt_q;
endmodule

// File: tb/tb_ram_true_dp_rf_wre_param.sv
// Directed bench for ram_true_dp_rf_wre_param: reset, read-first, byte lanes, collisions,
// hold, counter saturation (small CNT_WIDTH) and back-to-back dual-port streaming.
module tb_ram_true_dp_rf_wre_param;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int BW = 8;
  localparam int CW = 4;
  localparam int NB = DW / BW;
`ifdef RAM_TDP_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_true_dp_rf_wre_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW), .CNT_WIDTH(CW)) bus ();

  ram_true_dp_rf_wre_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [CW-1:0] exp_cnt = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.weA = 1'b0; bus.weB = 1'b0; bus.reA = 1'b0; bus.reB = 1'b0;
    bus.beA = '0;   bus.beB = '0;
    bus.addrA = '0; bus.addrB = '0;
    bus.dinA = '0;  bus.dinB = '0;
  endtask

  task automatic bump_cnt();
    if (exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic wr_a(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    bus.weA = 1'b1; bus.addrA = a; bus.dinA = d; bus.beA = be;
    step();
    idle();
  endtask

  task automatic wr_b(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    bus.weB = 1'b1; bus.addrB = a; bus.dinB = d; bus.beB = be;
    step();
    idle();
  endtask

  task automatic rd_a(input logic [AW-1:0] a, output logic [DW-1:0] d);
    bus.reA = 1'b1; bus.addrA = a;
    step();
    idle();
    repeat (LAT - 1) step();
    d = bus.doutA;
  endtask

  task automatic rd_b(input logic [AW-1:0] a, output logic [DW-1:0] d);
    bus.reB = 1'b1; bus.addrB = a;
    step();
    idle();
    repeat (LAT - 1) step();
    d = bus.doutB;
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    idle();
    repeat (2) step();
    rst = 1'b0;
    step();
    total++;
    if (bus.doutA !== '0 || bus.doutB !== '0 || bus.collision !== 1'b0 || bus.collision_cnt !== '0) begin
      bad++;
      $display("FAIL reset_init doutA=%h doutB=%h coll=%b cnt=%h want all zero",
               bus.doutA, bus.doutB, bus.collision, bus.collision_cnt);
    end
    wr_a(9'd10, 32'hDEADBEEF, 4'hF);
    rd_a(9'd10, d);
    total++;
    if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL reset_preload got=%h want=%h", d, 32'hDEADBEEF); end
    bus.weA = 1'b1; bus.weB = 1'b1; bus.addrA = 9'd400; bus.addrB = 9'd400;
    bus.beA = 4'hF; bus.beB = 4'hF; bus.dinA = 32'h1; bus.dinB = 32'h2;
    step();
    idle();
    bump_cnt();
    total++;
    if (bus.collision !== 1'b1 || bus.collision_cnt !== exp_cnt) begin
      bad++; $display("FAIL reset_precoll coll=%b cnt=%h want coll=1 cnt=%h", bus.collision, bus.collision_cnt, exp_cnt);
    end
    // mid-stream: a read of 10 and a blocked overwrite of 10 are in flight when rst rises
    bus.reA = 1'b1; bus.addrA = 9'd10;
    bus.weB = 1'b1; bus.addrB = 9'd10; bus.beB = 4'hF; bus.dinB = 32'h0BADF00D;
    rst = 1'b1;
    #1;
    exp_cnt = '0;
    total++;
    if (bus.doutA !== '0 || bus.doutB !== '0 || bus.collision !== 1'b0 || bus.collision_cnt !== '0) begin
      bad++;
      $display("FAIL reset_async doutA=%h doutB=%h coll=%b cnt=%h want all zero",
               bus.doutA, bus.doutB, bus.collision, bus.collision_cnt);
    end
    repeat (2) step();
    idle();
    rst = 1'b0;
    step();
    rd_a(9'd10, d);
    total++;
    if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL reset_retain got=%h want=%h", d, 32'hDEADBEEF); end
  endtask

  task automatic test_read_first();
    logic [DW-1:0] d;
    wr_a(9'd5, 32'h11111111, 4'hF);
    bus.weA = 1'b1; bus.reA = 1'b1; bus.addrA = 9'd5; bus.dinA = 32'h22222222; bus.beA = 4'hF;
    bus.reB = 1'b1; bus.addrB = 9'd5;
    step();
    idle();
    repeat (LAT - 1) step();
    total++;
    if (bus.doutA !== 32'h11111111) begin bad++; $display("FAIL rf_same_port got=%h want=%h", bus.doutA, 32'h11111111); end
    total++;
    if (bus.doutB !== 32'h11111111) begin bad++; $display("FAIL rf_cross_port got=%h want=%h", bus.doutB, 32'h11111111); end
    total++;
    if (bus.collision_cnt !== exp_cnt) begin bad++; $display("FAIL rf_no_coll cnt=%h want=%h", bus.collision_cnt, exp_cnt); end
    rd_a(9'd5, d);
    total++;
    if (d !== 32'h22222222) begin bad++; $display("FAIL rf_new_data got=%h want=%h", d, 32'h22222222); end
  endtask

  task automatic test_byte_lanes();
    logic [DW-1:0] d;
    wr_a(9'd7, 32'hAABBCCDD, 4'hF);
    wr_a(9'd7, 32'h11223344, 4'b0101);
    bus.weB = 1'b0; bus.beB = 4'hF; bus.addrB = 9'd7; bus.dinB = 32'h0;
    step();
    idle();
    rd_b(9'd7, d);
    total++;
    if (d !== 32'hAA22CC44) begin bad++; $display("FAIL lanes_a got=%h want=%h", d, 32'hAA22CC44); end
    wr_b(9'd8, 32'h12345678, 4'hF);
    wr_b(9'd8, 32'h00000000, 4'b1000);
    rd_a(9'd8, d);
    total++;
    if (d !== 32'h00345678) begin bad++; $display("FAIL lanes_b got=%h want=%h", d, 32'h00345678); end
  endtask

  task automatic test_collision();
    logic [DW-1:0] d;
    wr_b(9'd300, 32'hFFFFFFFF, 4'hF);
    bus.weA = 1'b1; bus.weB = 1'b1; bus.addrA = 9'd300; bus.addrB = 9'd300;
    bus.beA = 4'b0011; bus.beB = 4'b0110; bus.dinA = 32'h000000A1; bus.dinB = 32'h0000B200;
    step();
    idle();
    bump_cnt();
    total++;
    if (bus.collision !== 1'b1 || bus.collision_cnt !== exp_cnt) begin
      bad++; $display("FAIL coll_pulse coll=%b cnt=%h want coll=1 cnt=%h", bus.collision, bus.collision_cnt, exp_cnt);
    end
    step();
    total++;
    if (bus.collision !== 1'b0) begin bad++; $display("FAIL coll_one_cycle coll=%b want=0", bus.collision); end
    rd_a(9'd300, d);
    total++;
    if (d !== 32'hFF0000A1) begin bad++; $display("FAIL coll_data got=%h want=%h", d, 32'hFF0000A1); end
    wr_a(9'd301, 32'h0, 4'hF);
    bus.weA = 1'b1; bus.weB = 1'b1; bus.addrA = 9'd301; bus.addrB = 9'd301;
    bus.beA = 4'b0001; bus.beB = 4'b0010; bus.dinA = 32'h000000AA; bus.dinB = 32'h0000BB00;
    step();
    idle();
    total++;
    if (bus.collision !== 1'b0 || bus.collision_cnt !== exp_cnt) begin
      bad++; $display("FAIL coll_disjoint coll=%b cnt=%h want coll=0 cnt=%h", bus.collision, bus.collision_cnt, exp_cnt);
    end
    rd_b(9'd301, d);
    total++;
    if (d !== 32'h0000BBAA) begin bad++; $display("FAIL coll_disjoint_data got=%h want=%h", d, 32'h0000BBAA); end
  endtask

  task automatic test_hold();
    logic [DW-1:0] d;
    wr_a(9'd20, 32'hCAFEF00D, 4'hF);
    rd_a(9'd20, d);
    total++;
    if (d !== 32'hCAFEF00D) begin bad++; $display("FAIL hold_load got=%h want=%h", d, 32'hCAFEF00D); end
    for (int i = 0; i < 10; i++) begin
      bus.weA = 1'b1; bus.reA = 1'b0; bus.addrA = 9'd20; bus.beA = 4'hF; bus.dinA = 32'h50000000 + i;
      step();
      total++;
      if (bus.doutA !== 32'hCAFEF00D) begin bad++; $display("FAIL hold_cycle%0d got=%h want=%h", i, bus.doutA, 32'hCAFEF00D); end
    end
    idle();
    rd_a(9'd20, d);
    total++;
    if (d !== 32'h50000009) begin bad++; $display("FAIL hold_after got=%h want=%h", d, 32'h50000009); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < (2 ** CW) + 3; i++) begin
      bus.weA = 1'b1; bus.weB = 1'b1; bus.addrA = 9'd500; bus.addrB = 9'd500;
      bus.beA = 4'b1000; bus.beB = 4'b1001; bus.dinA = 32'(i); bus.dinB = 32'(i);
      step();
      bump_cnt();
      total++;
      if (bus.collision_cnt !== exp_cnt) begin bad++; $display("FAIL sat_step%0d cnt=%h want=%h", i, bus.collision_cnt, exp_cnt); end
    end
    idle();
    step();
    total++;
    if (bus.collision_cnt !== 4'hF || bus.collision !== 1'b0) begin
      bad++; $display("FAIL sat_final cnt=%h coll=%b want cnt=f coll=0", bus.collision_cnt, bus.collision);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      bus.weA = 1'b1; bus.addrA = AW'(i);       bus.beA = 4'hF; bus.dinA = 32'hA0000000 + i;
      bus.weB = 1'b1; bus.addrB = AW'(256 + i); bus.beB = 4'hF; bus.dinB = 32'hB0000000 + i;
      step();
    end
    idle();
    for (int i = 0; i < 8 + LAT - 1; i++) begin
      if (i < 8) begin
        bus.reA = 1'b1; bus.addrA = AW'(256 + i);
        bus.reB = 1'b1; bus.addrB = AW'(i);
      end else begin
        idle();
      end
      step();
      if (i >= LAT - 1) begin
        total++;
        if (bus.doutA !== 32'hB0000000 + (i - LAT + 1) || bus.doutB !== 32'hA0000000 + (i - LAT + 1)) begin
          bad++;
          $display("FAIL b2b_read%0d doutA=%h doutB=%h want %h %h", i - LAT + 1, bus.doutA, bus.doutB,
                   32'hB0000000 + (i - LAT + 1), 32'hA0000000 + (i - LAT + 1));
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_read_first();
    test_byte_lanes();
    test_collision();
    test_hold();
    test_saturation();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
